// File: rtl/mac_package.sv
// rtl/mac_package.sv - shared types and constants for the MAC debug unit
//
// Purpose: debug register offsets, STATUS layout and a saturating increment
// helper used by mac_dbg_unit.
package mac_package;

  // Byte offset of PROBE[0]; PROBE[k] lives at MAC_DBG_PROBE_BASE + 4k.
  localparam logic [7:0] MAC_DBG_PROBE_BASE = 8'h40;

  typedef enum logic [7:0] {
    MAC_DBG_STATUS      = 8'h00,
    MAC_DBG_BUSY_CYC    = 8'h04,
    MAC_DBG_STALL_CYC   = 8'h08,
    MAC_DBG_JOB_CNT     = 8'h0C,
    MAC_DBG_TRACE_LEVEL = 8'h10,
    MAC_DBG_TRACE_POP   = 8'h14,
    MAC_DBG_CTRL        = 8'h18
  } mac_dbg_reg_e;

  typedef struct packed {
    logic [25:0] rsvd;
    logic        trace_ovf;
    logic        frozen;
    logic        job_active;
    logic        done;
    logic        started;
    logic        busy;
  } mac_dbg_status_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// rtl/hwpe_ctrl_intf_periph.sv - peripheral register port between cluster and HWPE
//
// Purpose: request/grant + response bundle of the cluster peripheral port.
// wen is active-low: wen=1 is a read, wen=0 is a write.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = 8
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// File: rtl/mac_dbg_trace_fifo.sv
// rtl/mac_dbg_trace_fifo.sv - small synchronous FIFO holding FSM state-transition records
//
// Purpose: DEPTH x WIDTH FIFO with show-ahead read data.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous clear (same effect as reset)
//   push, wdata write an entry; dropped when full unless a pop happens this cycle
//   pop         retire the head entry; ignored when empty
//   flush       empty the FIFO; wins over a same-cycle push
//   rdata       head entry (stale when empty)
//   full, empty, level  occupancy
module mac_dbg_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full    = cnt[AW];
  assign level   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mac_dbg_unit.sv
// rtl/mac_dbg_unit.sv - debug/observability shim in front of hwpe_ctrl_slave
//
// Purpose: serves accesses with add[DBG_ADDR_BIT]=1 from a local register
// window (status, perf counters, CTRL, probes, optional state trace) and
// forwards everything else to the slave.
// Optional feature macro: MAC_DBG_TRACE_EN (state-transition trace FIFO).
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous soft clear
//   start_i, done_i   job start / done pulses
//   stall_i           engine stalled
//   state_i           main FSM state
//   probe_i           N_PROBE raw 32-bit probe words
//   periph            upstream peripheral port
//   periph_slave      downstream port to hwpe_ctrl_slave
module mac_dbg_unit
  import mac_package::*;
#(
  parameter int unsigned N_PROBE      = 12,
  parameter int unsigned STATE_W      = 4,
  parameter int unsigned TRACE_DEPTH  = 8,
  parameter int unsigned DBG_ADDR_BIT = 12,
  parameter int unsigned ID_WIDTH     = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic                    done_i,
  input  logic                    stall_i,
  input  logic [STATE_W-1:0]      state_i,
  input  logic [N_PROBE-1:0][31:0] probe_i,
  hwpe_ctrl_intf_periph.slave     periph,
  hwpe_ctrl_intf_periph.master    periph_slave
);
  localparam int unsigned LVL_W = $clog2(TRACE_DEPTH) + 1;

  logic                dbg_sel, dbg_req, dbg_rd, dbg_wr;
  logic [7:0]          offset;
  logic [5:0]          probe_idx;
  logic                ctrl_wr, ctrl_clr;
  logic                busy_d, busy_q, started_q, done_q, frozen_q;
  logic [31:0]         busy_cyc_q, stall_cyc_q, job_cnt_q;
  logic [LVL_W-1:0]    trace_level;
  logic                trace_ovf;
  logic [31:0]         trace_data;
  mac_dbg_status_t     status;
  logic [31:0]         probe_word, rdata;
  logic                dest_dbg_q, dbg_rvalid_q;
  logic [31:0]         dbg_rdata_q;
  logic [ID_WIDTH-1:0] dbg_rid;

  assign offset    = periph.add[7:0];
  assign dbg_sel   = periph.add[DBG_ADDR_BIT];
  assign dbg_req   = periph.req & dbg_sel;
  assign dbg_rd    = dbg_req & periph.wen;
  assign dbg_wr    = dbg_req & ~periph.wen;
  assign probe_idx = offset[7:2] - MAC_DBG_PROBE_BASE[7:2];

  // Request side: everything but req is forwarded untouched.
  assign periph_slave.req  = periph.req & ~dbg_sel;
  assign periph_slave.add  = periph.add;
  assign periph_slave.wen  = periph.wen;
  assign periph_slave.be   = periph.be;
  assign periph_slave.data = periph.data;
  assign periph_slave.id   = periph.id;
  assign periph.gnt        = dbg_sel ? 1'b1 : periph_slave.gnt;

  assign ctrl_wr  = dbg_wr & (offset == MAC_DBG_CTRL);
  assign ctrl_clr = ctrl_wr & periph.data[0];
  assign busy_d   = start_i | (busy_q & ~done_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= 1'b0;
      started_q   <= 1'b0;
      done_q      <= 1'b0;
      frozen_q    <= 1'b0;
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
      job_cnt_q   <= '0;
    end else if (clear_i) begin
      busy_q      <= 1'b0;
      started_q   <= 1'b0;
      done_q      <= 1'b0;
      frozen_q    <= 1'b0;
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
      job_cnt_q   <= '0;
    end else begin
      busy_q <= busy_d;
      if (ctrl_wr) frozen_q <= periph.data[2];
      if (ctrl_clr) begin
        started_q   <= 1'b0;
        done_q      <= 1'b0;
        busy_cyc_q  <= '0;
        stall_cyc_q <= '0;
        job_cnt_q   <= '0;
      end else begin
        if (start_i) started_q <= 1'b1;
        // A new job start retires the previous done indication.
        if (start_i)     done_q <= 1'b0;
        else if (done_i) done_q <= 1'b1;
        if (!frozen_q) begin
          if (busy_d)            busy_cyc_q  <= sat_inc(busy_cyc_q);
          if (busy_d && stall_i) stall_cyc_q <= sat_inc(stall_cyc_q);
          if (done_i && busy_q)  job_cnt_q   <= sat_inc(job_cnt_q);
        end
      end
    end
  end

`ifdef MAC_DBG_TRACE_EN
  localparam int unsigned TS_W    = 32 - STATE_W;
  localparam int unsigned ENTRY_W = TS_W + STATE_W;

  logic [STATE_W-1:0] state_q;
  logic               trace_push, trace_pop, trace_flush;
  logic               trace_full, trace_empty, trace_ovf_q;
  logic [ENTRY_W-1:0] trace_head;
  logic [LVL_W-1:0]   trace_level_w;

  assign trace_push  = (state_i != state_q) & ~frozen_q;
  assign trace_pop   = dbg_rd & (offset == MAC_DBG_TRACE_POP);
  assign trace_flush = ctrl_wr & periph.data[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= '0;
      trace_ovf_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= '0;
      trace_ovf_q <= 1'b0;
    end else begin
      state_q <= state_i;
      if (ctrl_clr)
        trace_ovf_q <= 1'b0;
      // Overflow only when the push is really lost: a same-cycle pop frees a slot.
      else if (trace_push && trace_full && !trace_pop && !trace_flush)
        trace_ovf_q <= 1'b1;
    end
  end

  mac_dbg_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (clear_i),
    .push  (trace_push),
    .pop   (trace_pop),
    .flush (trace_flush),
    .wdata ({busy_cyc_q[TS_W-1:0], state_i}),
    .rdata (trace_head),
    .full  (trace_full),
    .empty (trace_empty),
    .level (trace_level_w)
  );

  assign trace_level = trace_level_w;
  assign trace_ovf   = trace_ovf_q;
  assign trace_data  = trace_empty ? 32'd0 : trace_head;
`else
  logic unused_ok;
  assign unused_ok   = ^state_i;
  assign trace_level = '0;
  assign trace_ovf   = 1'b0;
  assign trace_data  = '0;
`endif

  always_comb begin
    status            = '0;
    status.busy       = busy_q;
    status.started    = started_q;
    status.done       = done_q;
    status.job_active = busy_q;
    status.frozen     = frozen_q;
    status.trace_ovf  = trace_ovf;
  end

  always_comb begin
    probe_word = '0;
    for (int k = 0; k < N_PROBE; k++) begin
      if (probe_idx == 6'(k)) probe_word = probe_i[k];
    end
    rdata = '0;
    if (offset >= MAC_DBG_PROBE_BASE) begin
      rdata = probe_word;
    end else begin
      case (offset)
        MAC_DBG_STATUS:      rdata = status;
        MAC_DBG_BUSY_CYC:    rdata = busy_cyc_q;
        MAC_DBG_STALL_CYC:   rdata = stall_cyc_q;
        MAC_DBG_JOB_CNT:     rdata = job_cnt_q;
        MAC_DBG_TRACE_LEVEL: rdata = 32'(trace_level);
        MAC_DBG_TRACE_POP:   rdata = trace_data;
        MAC_DBG_CTRL:        rdata = {29'b0, frozen_q, 2'b0};
        default:             rdata = '0;
      endcase
    end
  end

  // Response path: data captured in the request cycle, returned one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dest_dbg_q   <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else if (clear_i) begin
      dest_dbg_q   <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      if (periph.req && periph.gnt) dest_dbg_q <= dbg_sel;
      dbg_rvalid_q <= dbg_req;
      dbg_rdata_q  <= dbg_rd ? rdata : 32'd0;
    end
  end

  assign dbg_rid        = '0;
  assign periph.r_valid = dest_dbg_q ? dbg_rvalid_q : periph_slave.r_valid;
  assign periph.r_data  = dest_dbg_q ? dbg_rdata_q  : periph_slave.r_data;
  assign periph.r_id    = dest_dbg_q ? dbg_rid      : periph_slave.r_id;

endmodule

// File: tb/tb_mac_dbg_unit.sv
// tb/tb_mac_dbg_unit.sv - directed self-checking bench for mac_dbg_unit
module tb_mac_dbg_unit;

`ifdef MAC_DBG_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear_i = 1'b0, start_i = 1'b0, done_i = 1'b0, stall_i = 1'b0;
  logic [3:0]        state_i = '0;
  logic [11:0][31:0] probe = '0;
  int                tests = 0, fails = 0;
  logic [31:0]       d;
  logic              s_rv;
  logic [31:0]       s_rd;
  logic [9:0]        s_rid;

  hwpe_ctrl_intf_periph #(.ID_WIDTH(10)) p_if ();
  hwpe_ctrl_intf_periph #(.ID_WIDTH(10)) ps_if ();

  mac_dbg_unit #(
    .N_PROBE(12), .STATE_W(4), .TRACE_DEPTH(8), .DBG_ADDR_BIT(12), .ID_WIDTH(10)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i),
    .done_i(done_i), .stall_i(stall_i), .state_i(state_i), .probe_i(probe),
    .periph(p_if), .periph_slave(ps_if)
  );

  always #5 clk = ~clk;

  // Slave model: always grants, answers one cycle later with a tagged address.
  always @(posedge clk) begin
    s_rv  <= ps_if.req;
    s_rd  <= 32'hA000_0000 | ps_if.add;
    s_rid <= ps_if.id;
  end
  assign ps_if.gnt     = 1'b1;
  assign ps_if.r_valid = s_rv;
  assign ps_if.r_data  = s_rd;
  assign ps_if.r_id    = s_rid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dbg_acc(input logic [7:0] off, input logic wr, input logic [31:0] wd,
                         output logic [31:0] rd);
    @(negedge clk);
    p_if.req  = 1'b1;
    p_if.add  = 32'h1000 | off;
    p_if.wen  = ~wr;
    p_if.data = wd;
    #1;
    chk("dbg_gnt", p_if.gnt, 1);
    chk("slave_req_gated", ps_if.req, 0);
    chk("rvalid_req_cycle", p_if.r_valid, 0);
    @(negedge clk);
    p_if.req = 1'b0;
    #1;
    chk("rvalid_resp", p_if.r_valid, 1);
    chk("dbg_rid", p_if.r_id, 0);
    rd = p_if.r_data;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    dbg_acc(off, 1'b0, 32'd0, v);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd);
    logic [31:0] v;
    dbg_acc(off, 1'b1, wd, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p_if.req = 0; p_if.add = 0; p_if.wen = 1; p_if.be = 4'hF; p_if.data = 0; p_if.id = 10'h2A;
    probe[0]  = 32'hDEAD_BEEF;
    probe[11] = 32'h1111_000B;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and probe window
    rd_chk("status_reset", 8'h00, 32'h0);
    rd_chk("busy_cyc_reset", 8'h04, 32'h0);
    rd_chk("probe0", 8'h40, 32'hDEAD_BEEF);
    rd_chk("probe11", 8'h6C, 32'h1111_000B);
    rd_chk("probe12_unmapped", 8'h70, 32'h0);
    rd_chk("unmapped_0x30", 8'h30, 32'h0);
    rd_chk("ctrl_reset", 8'h18, 32'h0);

    // Trace: 0 -> 1 -> 2 -> 1
    @(negedge clk) state_i = 4'd1;
    @(negedge clk) state_i = 4'd2;
    @(negedge clk) state_i = 4'd1;
    rd_chk("trace_level_3", 8'h10, TR ? 32'd3 : 32'd0);
    rd_chk("trace_pop_1", 8'h14, TR ? 32'd1 : 32'd0);
    rd_chk("trace_pop_2", 8'h14, TR ? 32'd2 : 32'd0);
    rd_chk("trace_pop_3", 8'h14, TR ? 32'd1 : 32'd0);
    rd_chk("trace_pop_empty", 8'h14, 32'd0);
    rd_chk("status_no_ovf", 8'h00, 32'h0);

    // Ten changes into an 8-deep FIFO
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) state_i = 4'(2 + i);
    end
    rd_chk("trace_level_full", 8'h10, TR ? 32'd8 : 32'd0);
    rd_chk("status_ovf", 8'h00, TR ? 32'h20 : 32'h0);
    rd_chk("trace_pop_oldest", 8'h14, TR ? 32'd2 : 32'd0);
    rd_chk("trace_level_7", 8'h10, TR ? 32'd7 : 32'd0);
    wr(8'h18, 32'h3);
    rd_chk("trace_level_flushed", 8'h10, 32'd0);
    rd_chk("status_cleared", 8'h00, 32'h0);

    // Job: start, 10 busy cycles (3 stalled), done
    @(negedge clk) start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      stall_i = (i < 3);
    end
    @(negedge clk);
    stall_i = 1'b0;
    done_i  = 1'b1;
    @(negedge clk) done_i = 1'b0;
    rd_chk("busy_cyc_11", 8'h04, 32'd11);
    rd_chk("stall_cyc_3", 8'h08, 32'd3);
    rd_chk("job_cnt_1", 8'h0C, 32'd1);
    rd_chk("status_done", 8'h00, 32'h6);
    wr(8'h04, 32'h55);
    rd_chk("busy_cyc_ro", 8'h04, 32'd11);

    // Alternating slave / debug accesses, back to back
    @(negedge clk);
    p_if.req = 1'b1; p_if.wen = 1'b1; p_if.add = 32'h20;
    #1;
    chk("alt_slave_gnt", p_if.gnt, 1);
    chk("alt_slave_req", ps_if.req, 1);
    @(negedge clk);
    p_if.add = 32'h1004;
    #1;
    chk("alt_slave_rvalid", p_if.r_valid, 1);
    chk("alt_slave_rdata", p_if.r_data, 32'hA000_0020);
    chk("alt_slave_rid", p_if.r_id, 32'h2A);
    chk("alt_dbg_gated", ps_if.req, 0);
    @(negedge clk);
    p_if.add = 32'h20;
    #1;
    chk("alt_dbg_rvalid", p_if.r_valid, 1);
    chk("alt_dbg_rdata", p_if.r_data, 32'd11);
    chk("alt_dbg_rid", p_if.r_id, 0);
    @(negedge clk);
    p_if.req = 1'b0;
    #1;
    chk("alt_slave2_rvalid", p_if.r_valid, 1);
    chk("alt_slave2_rdata", p_if.r_data, 32'hA000_0020);

    // Freeze while busy
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    wr(8'h18, 32'h4);
    rd_chk("frozen_busy_a", 8'h04, 32'd14);
    repeat (5) @(negedge clk);
    rd_chk("frozen_busy_b", 8'h04, 32'd14);
    rd_chk("status_frozen", 8'h00, 32'h1B);
    rd_chk("ctrl_frozen", 8'h18, 32'h4);
    wr(8'h18, 32'h0);
    rd_chk("unfrozen_busy", 8'h04, 32'd15);
    @(negedge clk) done_i = 1'b1;
    @(negedge clk) done_i = 1'b0;
    rd_chk("job_cnt_2", 8'h0C, 32'd2);
    rd_chk("status_done2", 8'h00, 32'h6);

    // Reset between a debug request and its response
    @(negedge clk);
    p_if.req = 1'b1; p_if.wen = 1'b1; p_if.add = 32'h1040;
    #2 rst_n = 1'b0;
    @(negedge clk);
    p_if.req = 1'b0;
    #1;
    chk("rst_drops_rvalid", p_if.r_valid, 0);
    rst_n = 1'b1;
    rd_chk("busy_cyc_after_rst", 8'h04, 32'd0);
    rd_chk("job_cnt_after_rst", 8'h0C, 32'd0);

    // Soft clear
    @(negedge clk) start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk) clear_i = 1'b0;
    rd_chk("status_after_clear", 8'h00, 32'h0);
    rd_chk("busy_cyc_after_clear", 8'h04, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
